// File: rtl/fifo_pkg.sv
// Shared types and helpers for the AXI-Stream FIFO.
package fifo_pkg;

    typedef enum logic {INIT, RUN} state_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM with registered read and write-through bypass on address match.
module fifo_sdp_ram #(
    parameter  int unsigned WIDTH = 29,
    parameter  int unsigned SIZE  = 8,
    localparam int unsigned AW    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The array read returns the pre-write value, so a same-address write must be forwarded.
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_stream_fifo.sv
// AXI-Stream FIFO carrying TDATA+TLAST with fill/free/packet counts and synchronous flush.
module axis_stream_fifo import fifo_pkg::*; #(
    parameter  int unsigned DATA_W    = 28,
    parameter  int unsigned DEPTH     = 8,
    parameter  int unsigned AF_THRESH = DEPTH - 2,
    parameter  int unsigned AE_THRESH = 1,
    localparam int unsigned CNT_W     = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [CNT_W-1:0]  fill,
    output logic [CNT_W-1:0]  free,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, raddr;
    logic [CNT_W-1:0]   fill_q, fill_d, pkt_q, pkt_d;
    logic               run, wr, rd, wr_last, rd_last;
    logic [DATA_W:0]    ram_rdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign run      = (state_q == RUN);
    assign s_tready = run & (fill_q < CNT_W'(DEPTH)) & ~flush;
    assign m_tvalid = run & (fill_q != '0) & ~flush;
    assign wr       = s_tvalid & s_tready;
    assign rd       = m_tvalid & m_tready;
    assign wr_last  = wr & s_tlast;
    assign rd_last  = rd & m_tlast;

    // Read ahead so the next head word is already registered when the current one leaves.
    assign raddr    = rd ? ptr_inc(tail_q) : tail_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fill_d  = fill_q;
        pkt_d   = pkt_q;
        unique case (state_q)
            INIT: begin
                state_d = RUN;
                head_d  = '0;
                tail_d  = '0;
                fill_d  = '0;
                pkt_d   = '0;
            end
            RUN: begin
                if (flush) begin
                    head_d = '0;
                    tail_d = '0;
                    fill_d = '0;
                    pkt_d  = '0;
                end else begin
                    if (wr) head_d = ptr_inc(head_q);
                    if (rd) tail_d = ptr_inc(tail_q);
                    if (wr && !rd) fill_d = fill_q + 1'b1;
                    if (rd && !wr) fill_d = fill_q - 1'b1;
                    if (wr_last && !rd_last) pkt_d = pkt_q + 1'b1;
                    if (rd_last && !wr_last) pkt_d = pkt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            pkt_q   <= pkt_d;
        end
    end

    fifo_sdp_ram #(
        .WIDTH (DATA_W + 1),
        .SIZE  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr),
        .waddr_i (head_q),
        .wdata_i ({s_tlast, s_tdata}),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    assign m_tlast      = ram_rdata[DATA_W];
    assign m_tdata      = ram_rdata[DATA_W-1:0];
    assign fill         = fill_q;
    assign pkt_count    = pkt_q;
    assign free         = CNT_W'(DEPTH) - fill_q;
    assign almost_full  = (fill_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (fill_q <= CNT_W'(AE_THRESH));

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed bench for axis_stream_fifo: vector table plus multi-cycle corner sequences.
module tb_axis_stream_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [27:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [27:0] m_tdata;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [3:0]  fill, free, pkt_count;
    logic        almost_full, almost_empty;

    logic [27:0] sd6 = '0;
    logic        sl6 = 1'b0;
    logic        sv6 = 1'b0;
    logic        srdy6;
    logic [27:0] md6;
    logic        ml6;
    logic        mv6;
    logic        mr6 = 1'b0;
    logic [2:0]  fill6, free6, pkt6;
    logic        af6, ae6;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axis_stream_fifo #(.DATA_W(28), .DEPTH(8)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .fill(fill), .free(free), .almost_full(almost_full), .almost_empty(almost_empty),
        .pkt_count(pkt_count)
    );

    axis_stream_fifo #(.DATA_W(28), .DEPTH(6)) u_dut6 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .s_tdata(sd6), .s_tlast(sl6), .s_tvalid(sv6), .s_tready(srdy6),
        .m_tdata(md6), .m_tlast(ml6), .m_tvalid(mv6), .m_tready(mr6),
        .fill(fill6), .free(free6), .almost_full(af6), .almost_empty(ae6),
        .pkt_count(pkt6)
    );

    typedef struct {
        logic        sv;
        logic [27:0] sd;
        logic        sl;
        logic        mr;
        logic        e_srdy;
        logic        e_mvld;
        logic [27:0] e_data;
        logic        e_last;
        int          e_fill;
        int          e_pkt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sv, input logic [27:0] sd, input logic sl, input logic mr,
                         input logic fl);
        s_tvalid = sv;
        s_tdata  = sd;
        s_tlast  = sl;
        m_tready = mr;
        flush    = fl;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        int q6_idx;
        logic [28:0] q6[$];
        logic [28:0] head;
        int next_val;

        //            sv    sd        sl   mr   srdy mvld data      last fill pkt
        vecs[0] = '{1'b1, 28'hABC, 1'b1, 1'b0, 1'b0, 1'b0, 28'h0,   1'b0, 0, 0};
        vecs[1] = '{1'b1, 28'hABC, 1'b1, 1'b0, 1'b1, 1'b0, 28'h0,   1'b0, 0, 0};
        vecs[2] = '{1'b0, 28'h0,   1'b0, 1'b0, 1'b1, 1'b1, 28'hABC, 1'b1, 1, 1};
        vecs[3] = '{1'b1, 28'h111, 1'b0, 1'b1, 1'b1, 1'b1, 28'hABC, 1'b1, 1, 1};
        vecs[4] = '{1'b0, 28'h0,   1'b0, 1'b0, 1'b1, 1'b1, 28'h111, 1'b0, 1, 0};
        vecs[5] = '{1'b1, 28'h222, 1'b1, 1'b0, 1'b1, 1'b1, 28'h111, 1'b0, 1, 0};
        vecs[6] = '{1'b0, 28'h0,   1'b0, 1'b1, 1'b1, 1'b1, 28'h111, 1'b0, 2, 1};
        vecs[7] = '{1'b0, 28'h0,   1'b0, 1'b1, 1'b1, 1'b1, 28'h222, 1'b1, 1, 1};
        vecs[8] = '{1'b0, 28'h0,   1'b0, 1'b0, 1'b1, 1'b0, 28'h0,   1'b0, 0, 0};

        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Row 0 is the INIT cycle right after reset is released.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].sv, vecs[i].sd, vecs[i].sl, vecs[i].mr, 1'b0);
            #1;
            chk($sformatf("vec%0d s_tready", i), 32'(s_tready), 32'(vecs[i].e_srdy));
            chk($sformatf("vec%0d m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].e_mvld));
            chk($sformatf("vec%0d fill", i), 32'(fill), 32'(vecs[i].e_fill));
            chk($sformatf("vec%0d free", i), 32'(free), 32'(8 - vecs[i].e_fill));
            chk($sformatf("vec%0d pkt_count", i), 32'(pkt_count), 32'(vecs[i].e_pkt));
            chk($sformatf("vec%0d almost_empty", i), 32'(almost_empty),
                32'(vecs[i].e_fill <= 1));
            chk($sformatf("vec%0d almost_full", i), 32'(almost_full), 32'(vecs[i].e_fill >= 6));
            if (vecs[i].e_mvld) begin
                chk($sformatf("vec%0d m_tdata", i), 32'(m_tdata), 32'(vecs[i].e_data));
                chk($sformatf("vec%0d m_tlast", i), 32'(m_tlast), 32'(vecs[i].e_last));
            end
            next_cycle();
        end

        // Fill to DEPTH with the reader stalled; head word must hold steady.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 28'(i), i == 7, 1'b0, 1'b0);
            #1;
            chk($sformatf("fill%0d s_tready", i), 32'(s_tready), 32'd1);
            chk($sformatf("fill%0d fill", i), 32'(fill), 32'(i));
            chk($sformatf("fill%0d almost_full", i), 32'(almost_full), 32'(i >= 6));
            if (i > 0) chk($sformatf("fill%0d stalled head", i), 32'(m_tdata), 32'd0);
            next_cycle();
        end
        drive(1'b1, 28'd9, 1'b1, 1'b0, 1'b0);
        #1;
        chk("full s_tready", 32'(s_tready), 32'd0);
        chk("full fill", 32'(fill), 32'd8);
        chk("full free", 32'(free), 32'd0);
        chk("full almost_full", 32'(almost_full), 32'd1);
        chk("full pkt_count", 32'(pkt_count), 32'd1);
        next_cycle();
        drive(1'b0, 28'd0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("refused write fill", 32'(fill), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d m_tvalid", i), 32'(m_tvalid), 32'd1);
            chk($sformatf("drain%0d m_tdata", i), 32'(m_tdata), 32'(i));
            chk($sformatf("drain%0d m_tlast", i), 32'(m_tlast), 32'(i == 7));
            chk($sformatf("drain%0d almost_empty", i), 32'(almost_empty), 32'((8 - i) <= 1));
            next_cycle();
            #1;
        end
        chk("drained m_tvalid", 32'(m_tvalid), 32'd0);
        chk("drained fill", 32'(fill), 32'd0);

        // Flush overrides both handshakes.
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 28'h10 + 28'(i), (i == 1) || (i == 3), 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b1, 28'h99, 1'b1, 1'b1, 1'b1);
        #1;
        chk("preflush fill", 32'(fill), 32'd5);
        chk("preflush pkt_count", 32'(pkt_count), 32'd2);
        chk("flush s_tready", 32'(s_tready), 32'd0);
        chk("flush m_tvalid", 32'(m_tvalid), 32'd0);
        next_cycle();
        drive(1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("postflush fill", 32'(fill), 32'd0);
        chk("postflush pkt_count", 32'(pkt_count), 32'd0);
        chk("postflush m_tvalid", 32'(m_tvalid), 32'd0);
        chk("postflush free", 32'(free), 32'd8);
        next_cycle();
        drive(1'b1, 28'h55, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 28'h0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("postflush wr m_tvalid", 32'(m_tvalid), 32'd1);
        chk("postflush wr m_tdata", 32'(m_tdata), 32'h55);
        next_cycle();
        drive(1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("postflush rd fill", 32'(fill), 32'd0);

        // Reset mid-operation with four words stored.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1'b1, 28'h20 + 28'(i), 1'b1, 1'b0, 1'b0);
        end
        next_cycle();
        drive(1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("prereset fill", 32'(fill), 32'd4);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        chk("reset fill", 32'(fill), 32'd0);
        chk("reset pkt_count", 32'(pkt_count), 32'd0);
        chk("reset m_tvalid", 32'(m_tvalid), 32'd0);
        chk("reset s_tready", 32'(s_tready), 32'd0);
        next_cycle();
        #1;
        chk("after init s_tready", 32'(s_tready), 32'd1);
        chk("after init fill", 32'(fill), 32'd0);

        // DEPTH=6 instance: streaming with a random reader across pointer wraps.
        next_val = 1;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            sv6 = 1'b1;
            sd6 = 28'(next_val);
            sl6 = next_val[0];
            mr6 = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("d6 c%0d fill", c), 32'(fill6), 32'(q6.size()));
            chk($sformatf("d6 c%0d m_tvalid", c), 32'(mv6), 32'(q6.size() != 0));
            if (mv6 && mr6) begin
                if (q6.size() == 0) begin
                    chk($sformatf("d6 c%0d unexpected read", c), 32'd1, 32'd0);
                end else begin
                    head = q6.pop_front();
                    chk($sformatf("d6 c%0d data", c), {3'b0, ml6, md6}, {3'b0, head});
                end
            end
            if (srdy6) begin
                q6.push_back({sl6, sd6});
                next_val++;
            end
        end
        next_cycle();
        sv6 = 1'b0;
        mr6 = 1'b1;
        q6_idx = 0;
        while (q6.size() != 0 && q6_idx < 10) begin
            #1;
            head = q6.pop_front();
            chk($sformatf("d6 drain%0d m_tvalid", q6_idx), 32'(mv6), 32'd1);
            chk($sformatf("d6 drain%0d data", q6_idx), {3'b0, ml6, md6}, {3'b0, head});
            q6_idx++;
            next_cycle();
        end
        #1;
        chk("d6 drained m_tvalid", 32'(mv6), 32'd0);
        chk("d6 drained fill", 32'(fill6), 32'd0);
        mr6 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
